// File: rtl/module_seg7_scan.sv
// Time-multiplexed 4-digit 7-segment driver for a packed BCD word.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module module_seg7_scan #(
    parameter int SCAN_DIV       = 27000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_bcd,
    input  logic        i_valid,
    output logic [6:0]  o_seg,
    output logic [3:0]  o_an,
    output logic [1:0]  o_digit
);

    localparam int               CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [6:0]       SEG_INV  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0]       AN_INV   = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;

    logic [15:0]      r_bcd;
    logic [CNT_W-1:0] r_scan_cnt;
    logic [1:0]       r_digit_idx;
    logic [6:0]       r_seg;
    logic [3:0]       r_an;
    logic [1:0]       r_digit;

    logic             w_scan_wrap;
    logic [3:0]       w_nibble;
    logic [6:0]       w_seg_code;
    logic [3:0]       w_lead_zero;
    logic             w_blank;
    logic [6:0]       w_seg_next;
    logic [3:0]       w_an_next;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bcd <= '0;
        end else if (i_valid) begin
            r_bcd <= i_bcd;
        end
    end

    assign w_scan_wrap = (r_scan_cnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= 2'd0;
        end else if (w_scan_wrap) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= r_digit_idx + 2'd1;
        end else begin
            r_scan_cnt  <= r_scan_cnt + CNT_W'(1);
        end
    end

    assign w_nibble = r_bcd[{r_digit_idx, 2'b00} +: 4];

    // Active-high g..a codes; anything outside 0-9 shows a dash
    always_comb begin
        w_seg_code = 7'h40;
        case (w_nibble)
            4'd0:    w_seg_code = 7'h3F;
            4'd1:    w_seg_code = 7'h06;
            4'd2:    w_seg_code = 7'h5B;
            4'd3:    w_seg_code = 7'h4F;
            4'd4:    w_seg_code = 7'h66;
            4'd5:    w_seg_code = 7'h6D;
            4'd6:    w_seg_code = 7'h7D;
            4'd7:    w_seg_code = 7'h07;
            4'd8:    w_seg_code = 7'h7F;
            4'd9:    w_seg_code = 7'h6F;
            default: w_seg_code = 7'h40;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is leading when it and every digit above it are zero; units never blanks
    assign w_lead_zero[3] = (r_bcd[15:12] == 4'h0);
    assign w_lead_zero[2] = w_lead_zero[3] && (r_bcd[11:8] == 4'h0);
    assign w_lead_zero[1] = w_lead_zero[2] && (r_bcd[7:4] == 4'h0);
    assign w_lead_zero[0] = 1'b0;
`else
    assign w_lead_zero = 4'b0000;
`endif

    assign w_blank    = w_lead_zero[r_digit_idx];
    assign w_seg_next = (w_blank ? 7'h00 : w_seg_code) ^ SEG_INV;
    assign w_an_next  = (4'b0001 << r_digit_idx) ^ AN_INV;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_seg   <= SEG_INV;
            r_an    <= AN_INV;
            r_digit <= 2'd0;
        end else begin
            r_seg   <= w_seg_next;
            r_an    <= w_an_next;
            r_digit <= r_digit_idx;
        end
    end

    assign o_seg   = r_seg;
    assign o_an    = r_an;
    assign o_digit = r_digit;

endmodule
